overlay_compositor: RTL and testbench
=====================================

Name: overlay_compositor

Overview:
Pixel-path stage between the raster timing generator (hsync/vsync/DE plus h/v counters) and the HDMI transmitter pins. It merges a rectangular overlay image, streamed from the DDR reader through a valid/ready interface, onto the background pixel stream. The overlay is buffered in a small FIFO. Timing outputs are delayed so they stay aligned with the output data.

Parameters:
hCountWidth, 12, width of horizontal counter input
vCountWidth, 12, width of vertical counter input
ovlWidth, 256, overlay width in pixels
ovlHeight, 256, overlay height in lines
fifoDepth, 16, overlay FIFO entries; power of 2, at least 4
underflowColour, 24'hFF00FF, colour emitted for an overlay pixel when the FIFO is empty

Ports:
clock  in  1  pixel clock
masterReset_n  in  1  asynchronous active-low reset
hCount  in  hCountWidth  horizontal pixel counter
vCount  in  vCountWidth  vertical pixel counter
deIn  in  1  data enable from DE generator
hSyncIn  in  1  horizontal sync, active high
vSyncIn  in  1  vertical sync, active high
bgIn  in  24  background pixel, aligned with deIn
enable  in  1  overlay enable (sw[0])
ovlX  in  hCountWidth  overlay left column
ovlY  in  vCountWidth  overlay top line
pixIn  in  24  overlay pixel from DDR reader
pixValid  in  1  pixIn valid
pixReady  out  1  FIFO accepts pixIn
frameStart  out  1  one-cycle pulse; DDR reader restarts at image base address
dataOut  out  24  composited pixel
deOut  out  1  deIn delayed by 2
hSyncOut  out  1  hSyncIn delayed by 2
vSyncOut  out  1  vSyncIn delayed by 2
underflow  out  1  sticky: at least one FIFO underflow this frame

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FIFO is empty, state is IDLE, latched window and latched enable are 0.
- Frame start event: rising edge of vSyncIn, taken from a registered copy of vSyncIn.
- State machine:
  - IDLE: pixReady=0. Go to FLUSH on the first frame-start event.
  - FLUSH: lasts one cycle. frameStart=1, FIFO pointers cleared, ovlX/ovlY/enable latched, underflow cleared, pixReady=0. Go to ACTIVE.
  - ACTIVE: pixReady = !full. Go to FLUSH on every frame-start event.
- Push: pixValid && pixReady. Data in the FIFO is undefined while pixReady=0.
- Window hit (stage 1): deIn && enableLatched && hCount>=xL && hCount<xL+ovlWidth && vCount>=yL && vCount<yL+ovlHeight.
  - Upper bounds are computed one bit wider than the counters, so there is no wrap-around.
  - Pixels of a window that falls partly outside the active area are never popped. The DDR reader is restarted each frame, so no corruption carries across frames.
- Pop: hit && !empty, performed in stage 1.
- Push and pop in the same cycle:
  - Both are legal when the FIFO is neither empty nor full; count is unchanged.
  - Empty: no bypass. The pop fails and an underflow is flagged.
  - Full: pixReady is already 0, so only the pop occurs.
- Stage 2 output, registered: dataOut is chosen in this order:
  - !deDelayed → 0.
  - hit with a successful pop → FIFO head.
  - hit with FIFO empty → underflowColour, and underflow set to 1.
  - otherwise → bgIn delayed by 1.
- Latency: exactly 2 clocks from inputs to dataOut, deOut, hSyncOut and vSyncOut, in every state including IDLE. In IDLE, dataOut is bgIn when deOut=1.
- Window and enable changes take effect only at the next FLUSH.
- A reset asserted mid-frame returns the block to IDLE, and overlay output resumes after the next frame start.

Decomposition:
- Shared package: the hCountWidth/vCountWidth defaults and the underflowColour constant, shared with the sync, DE and dataWrite blocks.
- One sub-module, overlay_fifo: synchronous FIFO, width 24, depth fifoDepth.
  - Ports: clock, masterReset_n, clear, push, pop, dIn, dOut (head, show-ahead), full, empty.
  - Pointers are one bit wider than the address so full and empty can be distinguished.

Test Plan:
- Reset mid-frame, then release → all outputs 0 during reset; pixReady=0 until the first vSyncIn rise; frameStart pulses once, 2 cycles after that rise.
- Window: ovlX=100, ovlY=50, ovlWidth=4, ovlHeight=2; FIFO pre-filled with 8 increasing values → dataOut equals those values at lines 50-51, columns 100-103, 2 cycles late; bgIn everywhere else; underflow=0.
- pixValid held low, window active → dataOut=24'hFF00FF on hit pixels; underflow=1; underflow clears at the next frameStart.
- Continuous pixValid, no hits → exactly fifoDepth pushes accepted, then pixReady=0; one pop → pixReady=1 on the next cycle.
- enable changes 0→1 mid-frame → no overlay pixels in the current frame; overlay present from the next frame.
- Window at ovlX=4095-2 with hCountWidth=12 → no false hits at hCount 0-1 (no wrap); deOut, hSyncOut and vSyncOut equal the inputs delayed by exactly 2.

Source files
------------

// File: rtl/overlay_compositor_pkg.sv
// Shared constants and types for the overlay compositor pixel path.
// Counter defaults and the underflow colour are also used by the sync, DE and dataWrite blocks.
package overlay_compositor_pkg;

  localparam int unsigned HCountWidthDefault = 12;
  localparam int unsigned VCountWidthDefault = 12;
  localparam int unsigned PixelWidth         = 24;

  localparam logic [PixelWidth-1:0] UnderflowColourDefault = 24'hFF00FF;

  typedef logic [PixelWidth-1:0] pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StActive
  } ovl_state_e;

endpackage

// File: rtl/overlay_compositor_if.sv
// Valid/ready overlay pixel stream from the DDR reader into the compositor.
interface overlay_compositor_if;
  import overlay_compositor_pkg::*;

  pixel_t pixIn;
  logic   pixValid;
  logic   pixReady;

  modport master (output pixIn, output pixValid, input pixReady);
  modport slave  (input pixIn, input pixValid, output pixReady);

endinterface

// File: rtl/overlay_fifo.sv
// Show-ahead synchronous FIFO buffering overlay pixels; clear empties it in one cycle.
module overlay_fifo
  import overlay_compositor_pkg::*;
#(
  parameter int unsigned fifoDepth = 16
) (
  input  logic   clock,
  input  logic   masterReset_n,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  pixel_t dIn,
  output pixel_t dOut,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AddrWidth = $clog2(fifoDepth);
  localparam logic [AddrWidth:0] PtrOne = {{AddrWidth{1'b0}}, 1'b1};

  // Extra MSB on each pointer separates full from empty when the addresses match.
  logic [AddrWidth:0] wr_ptr_q, rd_ptr_q;
  pixel_t             mem_q [fifoDepth];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                 (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
  assign dOut  = mem_q[rd_ptr_q[AddrWidth-1:0]];

  always_ff @(posedge clock or negedge masterReset_n) begin
    if (!masterReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !clear) mem_q[wr_ptr_q[AddrWidth-1:0]] <= dIn;
  end

endmodule

// File: rtl/overlay_compositor.sv
// Merges a FIFO-buffered rectangular overlay onto the background pixel stream with a fixed
// two-clock latency; timing signals are delayed to stay aligned with dataOut.
module overlay_compositor
  import overlay_compositor_pkg::*;
#(
  parameter int unsigned     hCountWidth     = HCountWidthDefault,
  parameter int unsigned     vCountWidth     = VCountWidthDefault,
  parameter int unsigned     ovlWidth        = 256,
  parameter int unsigned     ovlHeight       = 256,
  parameter int unsigned     fifoDepth       = 16,
  parameter logic [23:0]     underflowColour = UnderflowColourDefault
) (
  input  logic                   clock,
  input  logic                   masterReset_n,
  input  logic [hCountWidth-1:0] hCount,
  input  logic [vCountWidth-1:0] vCount,
  input  logic                   deIn,
  input  logic                   hSyncIn,
  input  logic                   vSyncIn,
  input  pixel_t                 bgIn,
  input  logic                   enable,
  input  logic [hCountWidth-1:0] ovlX,
  input  logic [vCountWidth-1:0] ovlY,
  overlay_compositor_if.slave    pix,
  output logic                   frameStart,
  output pixel_t                 dataOut,
  output logic                   deOut,
  output logic                   hSyncOut,
  output logic                   vSyncOut,
  output logic                   underflow
);

  localparam logic [hCountWidth:0] OvlWidthExt  = (hCountWidth + 1)'(ovlWidth);
  localparam logic [vCountWidth:0] OvlHeightExt = (vCountWidth + 1)'(ovlHeight);

  ovl_state_e             state_q;
  logic                   frame_start_q;
  logic [hCountWidth-1:0] x_l_q;
  logic [vCountWidth-1:0] y_l_q;
  logic                   en_l_q;

  logic   de_s1_q, hs_s1_q, vs_s1_q, hit_s1_q, pop_s1_q;
  pixel_t bg_s1_q, head_s1_q;
  logic   de_s2_q, hs_s2_q, vs_s2_q, underflow_q;
  pixel_t data_q, data_d;

  logic             fs_event, hit, pop, push, clear;
  logic             fifo_full, fifo_empty;
  pixel_t           fifo_head;
  logic [hCountWidth:0] x_end;
  logic [vCountWidth:0] y_end;

  // vs_s2_q is the previous stage-1 sample, so this is a rising edge of registered vSyncIn.
  assign fs_event = vs_s1_q & ~vs_s2_q;
  assign clear    = (state_q == StFlush);

  // One bit wider than the counters so a window near the right/bottom edge never wraps.
  assign x_end = {1'b0, x_l_q} + OvlWidthExt;
  assign y_end = {1'b0, y_l_q} + OvlHeightExt;
  assign hit   = deIn && en_l_q &&
                 (hCount >= x_l_q) && ({1'b0, hCount} < x_end) &&
                 (vCount >= y_l_q) && ({1'b0, vCount} < y_end);
  assign pop   = hit && !fifo_empty;

  assign pix.pixReady = (state_q == StActive) && !fifo_full;
  assign push         = pix.pixValid && pix.pixReady;

  overlay_fifo #(
    .fifoDepth (fifoDepth)
  ) u_fifo (
    .clock         (clock),
    .masterReset_n (masterReset_n),
    .clear         (clear),
    .push          (push),
    .pop           (pop),
    .dIn           (pix.pixIn),
    .dOut          (fifo_head),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  always_ff @(posedge clock or negedge masterReset_n) begin
    if (!masterReset_n) begin
      state_q       <= StIdle;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StActive: begin
          if (fs_event) begin
            state_q       <= StFlush;
            frame_start_q <= 1'b1;
          end
        end
        StFlush: state_q <= StActive;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge masterReset_n) begin
    if (!masterReset_n) begin
      x_l_q  <= '0;
      y_l_q  <= '0;
      en_l_q <= 1'b0;
    end else if (state_q == StFlush) begin
      x_l_q  <= ovlX;
      y_l_q  <= ovlY;
      en_l_q <= enable;
    end
  end

  always_ff @(posedge clock or negedge masterReset_n) begin
    if (!masterReset_n) begin
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hit_s1_q  <= 1'b0;
      pop_s1_q  <= 1'b0;
      bg_s1_q   <= '0;
      head_s1_q <= '0;
    end else begin
      de_s1_q  <= deIn;
      hs_s1_q  <= hSyncIn;
      vs_s1_q  <= vSyncIn;
      hit_s1_q <= hit;
      pop_s1_q <= pop;
      bg_s1_q  <= bgIn;
      if (pop) head_s1_q <= fifo_head;
    end
  end

  always_comb begin
    data_d = bg_s1_q;
    if (!de_s1_q) begin
      data_d = '0;
    end else if (pop_s1_q) begin
      data_d = head_s1_q;
    end else if (hit_s1_q) begin
      data_d = underflowColour;
    end
  end

  always_ff @(posedge clock or negedge masterReset_n) begin
    if (!masterReset_n) begin
      data_q      <= '0;
      de_s2_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      de_s2_q <= de_s1_q;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
      if (fs_event) begin
        underflow_q <= 1'b0;
      end else if (hit_s1_q && !pop_s1_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign frameStart = frame_start_q;
  assign dataOut    = data_q;
  assign deOut      = de_s2_q;
  assign hSyncOut   = hs_s2_q;
  assign vSyncOut   = vs_s2_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_overlay_compositor.sv
// Randomized bench for overlay_compositor: a queue-based frame model predicts every output.
module tb_overlay_compositor;

  localparam int unsigned OW = 4;
  localparam int unsigned OH = 2;
  localparam int unsigned FD = 8;
  localparam logic [23:0] Magenta = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        masterReset_n = 1'b1;
  logic [11:0] hCount = '0, vCount = '0, ovlX = '0, ovlY = '0;
  logic        deIn = 1'b0, hSyncIn = 1'b0, vSyncIn = 1'b0, enable = 1'b0;
  logic [23:0] bgIn = '0;
  logic        frameStart, deOut, hSyncOut, vSyncOut, underflow;
  logic [23:0] dataOut;

  overlay_compositor_if pix_if ();

  overlay_compositor #(
    .hCountWidth (12),
    .vCountWidth (12),
    .ovlWidth    (OW),
    .ovlHeight   (OH),
    .fifoDepth   (FD)
  ) dut (
    .clock         (clock),
    .masterReset_n (masterReset_n),
    .hCount        (hCount),
    .vCount        (vCount),
    .deIn          (deIn),
    .hSyncIn       (hSyncIn),
    .vSyncIn       (vSyncIn),
    .bgIn          (bgIn),
    .enable        (enable),
    .ovlX          (ovlX),
    .ovlY          (ovlY),
    .pix           (pix_if),
    .frameStart    (frameStart),
    .dataOut       (dataOut),
    .deOut         (deOut),
    .hSyncOut      (hSyncOut),
    .vSyncOut      (vSyncOut),
    .underflow     (underflow)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: frame start is seen one cycle after vSyncIn rises, the FIFO flushes and the
  // window latches one cycle later, and every output trails its inputs by two clocks.
  typedef struct {
    bit          de;
    bit          hs;
    bit          vs;
    bit          rise;
    bit          uf_set;
    logic [23:0] data;
  } stage_t;

  logic [23:0] m_q[$];
  stage_t      m_stage, m_exp;
  bit          m_active, m_en, m_prev_vs, m_uf, m_ready;
  int          m_pending, m_x, m_y;

  int pix_ctr = 1;
  int valid_pct = 100;
  int cyc = 0;
  int rst_cycle = -1;
  bit nxt_en = 1'b0;
  int nxt_x = 0, nxt_y = 0;

  function automatic void model_reset();
    m_q.delete();
    m_active  = 1'b0;
    m_en      = 1'b0;
    m_prev_vs = 1'b0;
    m_uf      = 1'b0;
    m_pending = 0;
    m_x       = 0;
    m_y       = 0;
    m_stage   = '{default: 0};
    m_exp     = '{default: 0};
  endfunction

  function automatic void model_edge();
    bit          rise, flush_now, hit, pop_ok, push;
    int          h, v;
    logic [23:0] head;
    stage_t      nx;
    rise      = vSyncIn && !m_prev_vs;
    m_prev_vs = vSyncIn;
    flush_now = (m_pending == 1);
    if (m_pending > 0) m_pending--;
    if (rise) m_pending = 2;
    push = pix_if.pixValid && m_ready;
    h    = int'(hCount);
    v    = int'(vCount);
    hit  = deIn && m_en && h >= m_x && h < m_x + int'(OW) && v >= m_y && v < m_y + int'(OH);
    pop_ok = 1'b0;
    head   = '0;
    if (hit && m_q.size() > 0) begin
      head   = m_q.pop_front();
      pop_ok = 1'b1;
    end
    if (flush_now) begin
      m_q.delete();
      m_x      = int'(ovlX);
      m_y      = int'(ovlY);
      m_en     = enable;
      m_active = 1'b1;
    end else if (push) begin
      m_q.push_back(pix_if.pixIn);
      pix_ctr++;
    end
    nx.de     = deIn;
    nx.hs     = hSyncIn;
    nx.vs     = vSyncIn;
    nx.rise   = rise;
    nx.uf_set = hit && !pop_ok;
    nx.data   = !deIn ? 24'h0 : pop_ok ? head : hit ? Magenta : bgIn;
    m_exp = m_stage;
    if (m_stage.rise) m_uf = 1'b0;
    else if (m_stage.uf_set) m_uf = 1'b1;
    m_stage = nx;
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, ".dataOut"}, dataOut, 0);
    check_eq({tag, ".deOut"}, deOut, 0);
    check_eq({tag, ".hSyncOut"}, hSyncOut, 0);
    check_eq({tag, ".vSyncOut"}, vSyncOut, 0);
    check_eq({tag, ".frameStart"}, frameStart, 0);
    check_eq({tag, ".underflow"}, underflow, 0);
    check_eq({tag, ".pixReady"}, pix_if.pixReady, 0);
  endtask

  task automatic do_reset();
    masterReset_n = 1'b0;
    #1;
    check_zero("rst");
    repeat (3) begin
      @(posedge clock);
      #1;
      check_zero("rst_hold");
    end
    masterReset_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    @(negedge clock);
    m_ready = m_active && (m_pending != 1) && (m_q.size() < FD);
    check_eq("pixReady", pix_if.pixReady, m_ready);
    @(posedge clock);
    model_edge();
    #1;
    check_eq("dataOut", dataOut, m_exp.data);
    check_eq("deOut", deOut, m_exp.de);
    check_eq("hSyncOut", hSyncOut, m_exp.hs);
    check_eq("vSyncOut", vSyncOut, m_exp.vs);
    check_eq("frameStart", frameStart, m_exp.rise);
    check_eq("underflow", underflow, m_uf);
  endtask

  task automatic drive(input bit d, input bit hs, input bit vs, input int hc, input int vc);
    if (cyc == rst_cycle) do_reset();
    deIn            = d;
    hSyncIn         = hs;
    vSyncIn         = vs;
    hCount          = 12'(hc);
    vCount          = 12'(vc);
    bgIn            = 24'($urandom);
    pix_if.pixValid = ($urandom_range(99) < valid_pct);
    pix_if.pixIn    = 24'(pix_ctr);
    step();
    cyc++;
  endtask

  // Mini raster: optional vsync, then `lines` active lines of `w` pixels from (h0, v0).
  // Window/enable requests in nxt_* are applied halfway through the frame.
  task automatic run_frame(input bit with_vs, input int h0, input int v0, input int w,
                           input int lines);
    if (with_vs) repeat (3) drive(1'b0, 1'b0, 1'b1, h0, v0 - 1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, h0, v0 - 1);
    for (int l = 0; l < lines; l++) begin
      if (l == lines / 2) begin
        enable = nxt_en;
        ovlX   = 12'(nxt_x);
        ovlY   = 12'(nxt_y);
      end
      for (int c = 0; c < w; c++) drive(1'b1, 1'b0, 1'b0, h0 + c, v0 + l);
      drive(1'b0, 1'b0, 1'b0, h0 + w, v0 + l);
      drive(1'b0, 1'b1, 1'b0, h0 + w + 1, v0 + l);
      drive(1'b0, 1'b1, 1'b0, h0 + w + 2, v0 + l);
      drive(1'b0, 1'b0, 1'b0, h0 + w + 3, v0 + l);
    end
  endtask

  initial begin
    pix_if.pixValid = 1'b0;
    pix_if.pixIn    = '0;
    model_reset();
    #2;
    do_reset();

    // Overlay requested but no frame start yet: background passes, no pixels accepted.
    enable = 1'b1; ovlX = 12'd100; ovlY = 12'd50;
    nxt_en = 1'b1; nxt_x = 100; nxt_y = 50;
    valid_pct = 100;
    run_frame(1'b0, 98, 48, 8, 5);
    run_frame(1'b1, 98, 48, 8, 5);
    run_frame(1'b1, 98, 48, 8, 5);

    // Starved FIFO, then recovery clears the sticky flag.
    valid_pct = 0;
    run_frame(1'b1, 98, 48, 8, 5);
    valid_pct = 100;
    run_frame(1'b1, 98, 48, 8, 5);

    // Enable toggled mid-frame only takes effect from the following frame.
    nxt_en = 1'b0;
    run_frame(1'b1, 98, 48, 8, 5);
    nxt_en = 1'b1;
    run_frame(1'b1, 98, 48, 8, 5);
    run_frame(1'b1, 98, 48, 8, 5);

    // Window at the right edge of the counter range; hCount wraps to 0/1 without hits.
    ovlX = 12'd4093; nxt_x = 4093;
    run_frame(1'b1, 4090, 48, 8, 5);
    run_frame(1'b1, 4090, 48, 8, 5);

    // Reset in the middle of an overlay line, then overlay resumes next frame.
    ovlX = 12'd100; nxt_x = 100;
    valid_pct = 70;
    rst_cycle = cyc + 30;
    run_frame(1'b1, 98, 48, 8, 5);
    run_frame(1'b1, 98, 48, 8, 5);
    run_frame(1'b1, 98, 48, 8, 5);

    for (int f = 0; f < 12; f++) begin
      valid_pct = $urandom_range(0, 100);
      nxt_en    = ($urandom_range(0, 3) != 0);
      nxt_x     = $urandom_range(94, 106);
      nxt_y     = $urandom_range(46, 53);
      run_frame(($urandom_range(0, 7) != 0), 98, 48, 8, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
